reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- Architectural general-purpose register file of the single-cycle MIPS datapath.
- Sits directly upstream of the ALU and supplies both ALU operands (rs to a, rt to b).
- Takes the write-back value (ALU result or load data) on the next rising clock edge.
- Two combinational read ports, one synchronous write port, one combinational debug read port. Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, width of each register and of every data port.
- ADDR_W, 5, register index width; number of registers NUM_REGS = 2**ADDR_W (32).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ra1  input  ADDR_W  read port 1 index (rs field).
- ra2  input  ADDR_W  read port 2 index (rt field).
- rd1  output  DATA_W  read port 1 data, drives ALU operand a.
- rd2  output  DATA_W  read port 2 data, drives ALU operand b.
- we  input  1  write enable from the control unit (RegWrite).
- wa  input  ADDR_W  write index (rd/rt after RegDst mux).
- wd  input  DATA_W  write data (after MemtoReg mux).
- dbg_addr  input  ADDR_W  debug/testbench read index.
- dbg_data  output  DATA_W  debug read data.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n, and this is fixed.
- Storage: NUM_REGS x DATA_W flops, indices 0..NUM_REGS-1.
- Reset:
  - rst_n low clears every register to 0 immediately, without waiting for clk.
  - While rst_n is low: rd1, rd2 and dbg_data read 0, and writes are ignored, including a clk edge that coincides with rst_n low.
  - First write can occur on the first rising edge after rst_n goes high.
- Write:
  - On the rising clk edge with we=1 and wa!=0, reg[wa] <= wd.
  - Visible on the read ports from that edge onward (latency 1 edge, subject to the optional bypass).
  - we=0: no state change.
- Register 0:
  - Writes with wa=0 are discarded.
  - Any read of index 0 returns 0 on every port, regardless of we/wa/wd.
- Read:
  - rd1 = reg[ra1], rd2 = reg[ra2], dbg_data = reg[dbg_addr].
  - Purely combinational, valid in the same cycle the index changes.
  - No read enable; reads have no side effects.
- Simultaneous events:
  - ra1 == ra2: both ports return identical data.
  - Read of the index being written this cycle (no bypass): the port returns the pre-edge (old) value until the edge, then the new value.
  - dbg_addr is never bypassed; it always shows stored state.
- Width: all data ports are full DATA_W, with no sign or zero extension inside this block. Indices outside 0..NUM_REGS-1 are impossible given ADDR_W.
- No X propagation: every register has a defined value after reset.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: write-through forwarding.
  - If we=1, wa!=0 and ra1==wa, rd1 = wd combinationally in the same cycle. The same rule applies independently to ra2/rd2.
  - Register-0 rule still wins: index 0 reads 0 even if wd != 0.
  - Bypass is gated off while rst_n is low.
  - Supports a future pipelined datapath where write-back and decode share a cycle.
- Not defined: no forwarding. Ports show only stored values, per the read rules above.

Test Plan:
- Reset: drive rst_n=0 mid-run after writing reg[5]=32'hDEADBEEF (no clk edge needed) -> rd1 with ra1=5 reads 32'h0 immediately. A we=1 edge during reset leaves reg[5]=0.
- Basic write/read:
  - Stimulus: we=1, wa=8, wd=32'h0000_1234, then one edge; we=0, ra1=8, ra2=8.
  - Response: rd1=rd2=32'h0000_1234, dbg_data (dbg_addr=8) = 32'h0000_1234.
- Register 0: we=1, wa=0, wd=32'hFFFF_FFFF, one edge -> rd1 (ra1=0) = 0, dbg_data (dbg_addr=0) = 0.
- Same-cycle read of write target:
  - Stimulus: reg[9]=32'h11; then we=1, wa=9, wd=32'h22, ra1=9, sampled before the edge.
  - Response without REG_FILE_BYPASS_EN: rd1=32'h11, then 32'h22 after the edge.
  - Response with the macro: rd1=32'h22 before the edge. dbg_data (dbg_addr=9) = 32'h11 before the edge in both builds.
- Sweep: write reg[i]=i*32'h0101_0101 for i=1..31 on consecutive edges, then read back all pairs (ra1=i, ra2=31-i) -> exact match; index 0 returns 0.
- we gating: we=0, wa=3, wd=32'hA5A5_A5A5 over 4 edges -> reg[3] keeps its prior value (0 after reset).

Source files
------------

// File: rtl/reg_file.sv
// 32x32 MIPS general-purpose register file: two combinational read ports, one write port, debug read.
// Optional write-through forwarding on rd1/rd2 when REG_FILE_BYPASS_EN is defined.
module reg_file #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              wr_en;

    // Index 0 is never written, so its flop stays at the reset value of zero.
    assign wr_en = we && (wa != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wa] <= wd;
        end
    end

`ifdef REG_FILE_BYPASS_EN
    logic byp1, byp2;
    assign byp1 = rst_n && wr_en && (ra1 == wa);
    assign byp2 = rst_n && wr_en && (ra2 == wa);
`endif

    always_comb begin
        rd1      = (ra1 == '0) ? '0 : regs_q[ra1];
        rd2      = (ra2 == '0) ? '0 : regs_q[ra2];
        dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
`ifdef REG_FILE_BYPASS_EN
        // wr_en already excludes index 0, so the zero-register rule is preserved.
        if (byp1) rd1 = wd;
        if (byp2) rd2 = wd;
`endif
    end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus queues expected port values, a monitor compares them.
// Expectations for the same-cycle read follow REG_FILE_BYPASS_EN when it is defined.
module tb_reg_file;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] ra1, ra2, wa, dbg_addr;
    logic [DATA_W-1:0] rd1, rd2, wd, dbg_data;
    logic              we;

    reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra1     (ra1),
        .ra2     (ra2),
        .rd1     (rd1),
        .rd2     (rd2),
        .we      (we),
        .wa      (wa),
        .wd      (wd),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;  // 1 = rd1, 2 = rd2, 3 = dbg_data
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    logic strobe = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic monitor_done = 1'b0;

    // Monitor: on each strobe, drain the queue and compare the presented outputs.
    initial begin
        forever begin
            @(posedge strobe);
            while (exp_q.size() > 0) begin
                exp_t        e;
                logic [31:0] act;
                e = exp_q.pop_front();
                case (e.port)
                    1:       act = rd1;
                    2:       act = rd2;
                    default: act = dbg_data;
                endcase
                n_checks++;
                if (act !== e.exp) begin
                    n_errors++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
            monitor_done = 1'b1;
        end
    end

    task automatic push(input int port, input logic [31:0] exp, input string name);
        exp_t e;
        e.port = port;
        e.exp  = exp;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic fire();
        #1 strobe = 1'b1;
        #1 strobe = 1'b0;
    endtask

    // One write on the next rising edge; inputs change only on falling edges.
    task automatic write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; wa = a; wd = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    logic [31:0] same_exp;

    initial begin
        rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0; dbg_addr = '0;

        // Reset state, with a write attempt pending on index 5 (bypass must be gated).
        @(negedge clk);
        we = 1'b1; wa = 5'd5; wd = 32'h1357_9BDF; ra1 = 5'd5; ra2 = 5'd5; dbg_addr = 5'd5;
        #1 push(1, 32'h0, "reset_rd1"); push(2, 32'h0, "reset_rd2"); push(3, 32'h0, "reset_dbg");
        fire();
        @(negedge clk);
        we = 1'b0;
        push(3, 32'h0, "reset_write_ignored");
        fire();
        rst_n = 1'b1;

        // Mid-run asynchronous reset clears a written register immediately.
        write(5'd5, 32'hDEAD_BEEF);
        ra1 = 5'd5; dbg_addr = 5'd5;
        push(1, 32'hDEAD_BEEF, "pre_reset_rd1");
        fire();
        @(negedge clk);
        #1 rst_n = 1'b0;
        push(1, 32'h0, "async_reset_rd1");
        push(3, 32'h0, "async_reset_dbg");
        fire();
        @(negedge clk);
        we = 1'b1; wa = 5'd5; wd = 32'hCAFE_F00D;
        @(negedge clk);
        we = 1'b0;
        push(3, 32'h0, "write_during_reset");
        fire();
        rst_n = 1'b1;

        // Basic write/read.
        write(5'd8, 32'h0000_1234);
        ra1 = 5'd8; ra2 = 5'd8; dbg_addr = 5'd8;
        push(1, 32'h0000_1234, "basic_rd1");
        push(2, 32'h0000_1234, "basic_rd2");
        push(3, 32'h0000_1234, "basic_dbg");
        fire();

        // Register 0 write is discarded, even during the write cycle.
        @(negedge clk);
        we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra1 = 5'd0; ra2 = 5'd0;
        push(1, 32'h0, "r0_same_cycle_rd1");
        fire();
        @(negedge clk);
        we = 1'b0; dbg_addr = 5'd0;
        push(1, 32'h0, "r0_rd1");
        push(2, 32'h0, "r0_rd2");
        push(3, 32'h0, "r0_dbg");
        fire();

        // Same-cycle read of the write target.
        write(5'd9, 32'h11);
`ifdef REG_FILE_BYPASS_EN
        same_exp = 32'h22;
`else
        same_exp = 32'h11;
`endif
        @(negedge clk);
        we = 1'b1; wa = 5'd9; wd = 32'h22; ra1 = 5'd9; ra2 = 5'd9; dbg_addr = 5'd9;
        push(1, same_exp, "same_cycle_rd1");
        push(2, same_exp, "same_cycle_rd2");
        push(3, 32'h11, "same_cycle_dbg");
        fire();
        @(negedge clk);
        we = 1'b0;
        push(1, 32'h22, "after_edge_rd1");
        push(3, 32'h22, "after_edge_dbg");
        fire();

        // we gating: four edges with we low must not touch reg[3].
        @(negedge clk);
        we = 1'b0; wa = 5'd3; wd = 32'hA5A5_A5A5;
        repeat (4) @(negedge clk);
        ra1 = 5'd3; dbg_addr = 5'd3;
        push(1, 32'h0, "we_gate_rd1");
        push(3, 32'h0, "we_gate_dbg");
        fire();

        // Sweep: consecutive writes, then paired read-back.
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            we = 1'b1; wa = 5'(i); wd = 32'(i) * 32'h0101_0101;
        end
        @(negedge clk);
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            ra1 = 5'(i); ra2 = 5'(31 - i); dbg_addr = 5'(i);
            push(1, 32'(i) * 32'h0101_0101, $sformatf("sweep_rd1_%0d", i));
            push(2, 32'(31 - i) * 32'h0101_0101, $sformatf("sweep_rd2_%0d", 31 - i));
            push(3, 32'(i) * 32'h0101_0101, $sformatf("sweep_dbg_%0d", i));
            fire();
        end

        #2;
        if (!monitor_done || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
